// File: rtl/gf180mcu_fd_sc_mcu7t5v0__invfilt_func.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__invfilt_func.sv - synchronised, glitch-filtered inverter stage
// Optional CHG pulse output: define GF180MCU_FD_SC_MCU7T5V0_INVFILT_CHG_EN.
module gf180mcu_fd_sc_mcu7t5v0__invfilt_func #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic I,
  output logic ZN,
  inout  wire  VDD,
  inout  wire  VSS
`ifdef GF180MCU_FD_SC_MCU7T5V0_INVFILT_CHG_EN
  ,
  output logic CHG
`endif
);

  localparam int CNT_W = $clog2(FILT_CNT + 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t             r_state, w_state_n;
  logic [SYNC_STAGES-1:0] r_sync;
  logic               r_filt, w_filt_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic               w_upd;
  logic               w_s_i;

  // Supplies are pin-compatibility only.
  wire w_unused_supply = VDD & VSS;

  assign w_s_i = r_sync[SYNC_STAGES-1];
  assign ZN    = ~r_filt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync  <= '0;
      r_filt  <= 1'b0;
      r_cnt   <= '0;
      r_state <= ST_STABLE;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], I};
      r_filt  <= w_filt_n;
      r_cnt   <= w_cnt_n;
      r_state <= w_state_n;
    end
  end

  // An unknown s_i falls into the "match" branch so filt never moves on X.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_filt_n  = r_filt;
    w_upd     = 1'b0;
    case (r_state)
      ST_STABLE: begin
        w_cnt_n = '0;
        if (w_s_i != r_filt) begin
          if (FILT_CNT == 1) begin
            w_filt_n = w_s_i;
            w_upd    = 1'b1;
          end else begin
            w_cnt_n   = CNT_W'(1);
            w_state_n = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (w_s_i != r_filt) begin
          if (r_cnt == CNT_W'(FILT_CNT - 1)) begin
            w_filt_n  = w_s_i;
            w_cnt_n   = '0;
            w_state_n = ST_STABLE;
            w_upd     = 1'b1;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end else begin
          w_cnt_n   = '0;
          w_state_n = ST_STABLE;
        end
      end
      default: begin
        w_cnt_n   = '0;
        w_state_n = ST_STABLE;
      end
    endcase
  end

`ifdef GF180MCU_FD_SC_MCU7T5V0_INVFILT_CHG_EN
  logic r_chg;
  always_ff @(posedge CLK) begin
    if (RST) r_chg <= 1'b0;
    else     r_chg <= w_upd;
  end
  assign CHG = r_chg;
`else
  wire w_unused_upd = w_upd;
`endif

endmodule
